// File: rtl/rsb_spec_controller_pkg.sv
// Shared types for the return-stack-buffer speculation controller:
// journal op codes, the journal entry layout and the controller FSM states.
package rsb_spec_controller_pkg;

    localparam int RSB_ADDR_WIDTH    = 32;
    localparam int RSB_STACK_DEPTH   = 8;
    localparam int RSB_JOURNAL_DEPTH = 8;

    // What a journaled speculative op did to the RSB, so it can be undone.
    typedef enum logic [1:0] {
        RSB_OP_NONE,
        RSB_OP_PUSH,
        RSB_OP_POP,
        RSB_OP_REPLACE
    } rsb_op_e;

    // addr holds the RSB top that the op destroyed (POP / REPLACE only).
    typedef struct packed {
        rsb_op_e                   op;
        logic [RSB_ADDR_WIDTH-1:0] addr;
    } rsb_journal_entry_t;

    typedef enum logic {
        CTRL_RUN,
        CTRL_UNWIND
    } ctrl_state_e;

endpackage

// File: rtl/rsb_spec_controller_if.sv
// Command/status bus between the speculation controller (master) and the
// return stack buffer (slave). top_addr/top_valid are the RSB's live top.
interface rsb_spec_controller_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  push_en;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic                  pop_en;
    logic [ADDR_WIDTH-1:0] top_addr;
    logic                  top_valid;

    modport master (output push_en, push_addr, pop_en, input top_addr, top_valid);
    modport slave  (input push_en, push_addr, pop_en, output top_addr, top_valid);
endinterface

// File: rtl/return_stack_buffer.sv
// Plain return stack buffer. push+pop in one cycle replaces the top
// (or pushes onto an empty stack); the top is read combinationally.
module return_stack_buffer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rsb_spec_controller_if.slave rsb
);
    localparam int IW = $clog2(STACK_DEPTH);
    localparam int CW = IW + 1;

    logic [ADDR_WIDTH-1:0] stack_reg [STACK_DEPTH];
    logic [CW-1:0]         cnt_reg;
    logic [CW-1:0]         cnt_next;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         top_idx;
    logic                  is_empty;
    logic                  is_full;

    assign is_empty      = (cnt_reg == '0);
    assign is_full       = (cnt_reg == CW'(STACK_DEPTH));
    assign top_idx       = IW'(cnt_reg - CW'(1));
    assign rsb.top_valid = !is_empty;
    assign rsb.top_addr  = is_empty ? '0 : stack_reg[top_idx];

    // Decode push/pop into one slot write and the next entry count.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = IW'(cnt_reg);
        cnt_next = cnt_reg;
        if (rsb.push_en && !rsb.pop_en) begin
            if (!is_full) begin
                wr_en    = 1'b1;
                cnt_next = cnt_reg + CW'(1);
            end
        end else if (!rsb.push_en && rsb.pop_en) begin
            if (!is_empty) cnt_next = cnt_reg - CW'(1);
        end else if (rsb.push_en && rsb.pop_en) begin
            wr_en = 1'b1;
            if (is_empty) begin
                wr_idx   = '0;
                cnt_next = CW'(1);
            end else begin
                wr_idx = top_idx;
            end
        end
    end

    // Entry count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
    end

    // Stack storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) stack_reg[wr_idx] <= rsb.push_addr;
    end
endmodule

// File: rtl/rsb_spec_controller_undo_journal.sv
// Double-ended undo journal: new entries enter at the write pointer, unwind
// takes them back from the same end (LIFO), commit retires from the read
// pointer (FIFO). Caller never pushes and pops in the same cycle.
module rsb_undo_journal
    import rsb_spec_controller_pkg::*;
#(
    parameter int JOURNAL_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_en,
    input  rsb_journal_entry_t            push_entry,
    input  logic                          pop_en,
    input  logic                          retire_en,
    output rsb_journal_entry_t            newest_entry,
    output logic [$clog2(JOURNAL_DEPTH):0] count,
    output logic                          full,
    output logic                          empty
);
    localparam int PW = $clog2(JOURNAL_DEPTH);
    localparam int CW = PW + 1;

    rsb_journal_entry_t mem_reg [JOURNAL_DEPTH];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic [PW-1:0]      newest_idx;
    logic               push_ok;
    logic               pop_ok;
    logic               retire_ok;

    assign full         = (count_reg == CW'(JOURNAL_DEPTH));
    assign empty        = (count_reg == '0);
    assign count        = count_reg;
    assign push_ok      = push_en && !full;
    assign pop_ok       = pop_en && !empty;
    assign retire_ok    = retire_en && !empty;
    assign newest_idx   = wr_ptr_reg - PW'(1);
    assign newest_entry = mem_reg[newest_idx];
    assign count_next   = count_reg + CW'(push_ok) - CW'(pop_ok) - CW'(retire_ok);

    // Pointer and count bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)        wr_ptr_reg <= wr_ptr_reg + PW'(1);
            else if (pop_ok)    wr_ptr_reg <= newest_idx;
            if (retire_ok)      rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) mem_reg[wr_ptr_reg] <= push_entry;
    end
endmodule

// File: rtl/rsb_spec_controller.sv
// Speculation controller for the return stack buffer: classifies fetch
// call/return ops into RSB commands, journals what each op destroyed, retires
// entries on commit and unwinds newest-first on flush.
module rsb_spec_controller
    import rsb_spec_controller_pkg::*;
#(
    parameter int ADDR_WIDTH    = RSB_ADDR_WIDTH,
    parameter int STACK_DEPTH   = RSB_STACK_DEPTH,
    parameter int JOURNAL_DEPTH = RSB_JOURNAL_DEPTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           fe_valid_i,
    input  logic                           fe_call_i,
    input  logic                           fe_ret_i,
    input  logic [ADDR_WIDTH-1:0]          fe_ret_addr_i,
    output logic                           fe_ready_o,
    output logic                           pred_valid_o,
    output logic [ADDR_WIDTH-1:0]          pred_target_o,
    input  logic                           commit_i,
    input  logic                           flush_i,
    rsb_spec_controller_if.master          rsb,
    output logic                           busy_o,
    output logic [$clog2(STACK_DEPTH):0]   occupancy_o
);
    localparam int OW  = $clog2(STACK_DEPTH) + 1;
    localparam int JCW = $clog2(JOURNAL_DEPTH) + 1;

    ctrl_state_e        state_reg;
    logic               busy_reg;
    logic [OW-1:0]      occ_reg;
    logic [OW-1:0]      occ_next;
    logic               run;
    logic               occ_empty;
    logic               occ_full;
    logic               accept;
    logic               commit_eff;
    logic               undo;
    logic               j_push;
    rsb_journal_entry_t j_entry;
    rsb_journal_entry_t j_newest;
    logic [JCW-1:0]     j_count;
    logic [JCW-1:0]     j_count_next;
    logic               j_full;
    logic               j_empty;
    logic               push_en;
    logic               pop_en;
    logic [ADDR_WIDTH-1:0] push_addr;

    assign run           = (state_reg == CTRL_RUN);
    assign occ_empty     = (occ_reg == '0);
    assign occ_full      = (occ_reg == OW'(STACK_DEPTH));
    assign fe_ready_o    = !rst_i && run && !flush_i && !j_full;
    assign accept        = fe_valid_i && fe_ready_o;
    assign pred_valid_o  = !rst_i && run && fe_valid_i && fe_ret_i && !occ_empty;
    assign pred_target_o = rsb.top_addr;
    assign commit_eff    = !rst_i && commit_i && !j_empty;
    // A lone remaining entry that is committed this cycle needs no undo.
    assign undo          = !rst_i && !run && !j_empty && !(commit_eff && j_count == JCW'(1));
    assign j_push        = accept && (fe_call_i || fe_ret_i);
    assign j_count_next  = j_count + JCW'(j_push) - JCW'(commit_eff) - JCW'(undo);
    assign rsb.push_en   = push_en;
    assign rsb.pop_en    = pop_en;
    assign rsb.push_addr = push_addr;
    assign busy_o        = busy_reg;
    assign occupancy_o   = occ_reg;

    // Zero-latency RSB commands: classify accepted ops, or undo the newest entry.
    always_comb begin
        push_en       = 1'b0;
        pop_en        = 1'b0;
        push_addr     = '0;
        occ_next      = occ_reg;
        j_entry.op    = RSB_OP_NONE;
        j_entry.addr  = '0;
        if (accept) begin
            unique case ({fe_call_i, fe_ret_i})
                2'b10: if (!occ_full) begin
                    push_en    = 1'b1;
                    push_addr  = fe_ret_addr_i;
                    j_entry.op = RSB_OP_PUSH;
                    occ_next   = occ_reg + OW'(1);
                end
                2'b01: if (!occ_empty) begin
                    pop_en       = 1'b1;
                    j_entry.op   = RSB_OP_POP;
                    j_entry.addr = RSB_ADDR_WIDTH'(rsb.top_addr);
                    occ_next     = occ_reg - OW'(1);
                end
                2'b11: begin
                    if (occ_empty) begin
                        push_en    = 1'b1;
                        push_addr  = fe_ret_addr_i;
                        j_entry.op = RSB_OP_PUSH;
                        occ_next   = occ_reg + OW'(1);
                    end else if (occ_full) begin
                        // No room to push after the pop: the call's address is dropped.
                        pop_en       = 1'b1;
                        j_entry.op   = RSB_OP_POP;
                        j_entry.addr = RSB_ADDR_WIDTH'(rsb.top_addr);
                        occ_next     = occ_reg - OW'(1);
                    end else begin
                        push_en      = 1'b1;
                        pop_en       = 1'b1;
                        push_addr    = fe_ret_addr_i;
                        j_entry.op   = RSB_OP_REPLACE;
                        j_entry.addr = RSB_ADDR_WIDTH'(rsb.top_addr);
                    end
                end
                default: ;
            endcase
        end else if (undo) begin
            unique case (j_newest.op)
                RSB_OP_PUSH: begin
                    pop_en   = 1'b1;
                    occ_next = occ_reg - OW'(1);
                end
                RSB_OP_POP: begin
                    push_en   = 1'b1;
                    push_addr = ADDR_WIDTH'(j_newest.addr);
                    occ_next  = occ_reg + OW'(1);
                end
                RSB_OP_REPLACE: begin
                    push_en   = 1'b1;
                    pop_en    = 1'b1;
                    push_addr = ADDR_WIDTH'(j_newest.addr);
                end
                default: ;
            endcase
        end
    end

    // RUN/UNWIND FSM with registered busy flag and shadow occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= CTRL_RUN;
            busy_reg  <= 1'b0;
            occ_reg   <= '0;
        end else begin
            occ_reg <= occ_next;
            unique case (state_reg)
                CTRL_RUN: if (flush_i && j_count_next != '0) begin
                    state_reg <= CTRL_UNWIND;
                    busy_reg  <= 1'b1;
                end
                CTRL_UNWIND: if (j_count_next == '0) begin
                    state_reg <= CTRL_RUN;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= CTRL_RUN;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    rsb_undo_journal #(
        .JOURNAL_DEPTH (JOURNAL_DEPTH)
    ) u_journal (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_en      (j_push),
        .push_entry   (j_entry),
        .pop_en       (undo),
        .retire_en    (commit_eff),
        .newest_entry (j_newest),
        .count        (j_count),
        .full         (j_full),
        .empty        (j_empty)
    );
endmodule

// File: tb/tb_rsb_spec_controller.sv
// Bench for rsb_spec_controller driving a real return_stack_buffer.
// Reference model: the speculative stack as a value plus a queue holding the
// stack as it was before each uncommitted op; flush restores older snapshots.
module tb_rsb_spec_controller;
    typedef struct packed {
        logic [3:0]       n;
        logic [7:0][31:0] e;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst, fe_valid, fe_call, fe_ret, commit, flush;
    logic [31:0] fe_addr;
    logic        fe_ready, pred_valid, busy;
    logic [31:0] pred_target;
    logic [3:0]  occ;

    int    checks = 0;
    int    errors = 0;
    snap_t cur;
    snap_t snaps[$];
    bit    unw;

    always #5 clk = ~clk;

    rsb_spec_controller_if #(.ADDR_WIDTH(32)) rsb_if ();

    rsb_spec_controller #(.ADDR_WIDTH(32), .STACK_DEPTH(8), .JOURNAL_DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .fe_valid_i(fe_valid), .fe_call_i(fe_call), .fe_ret_i(fe_ret),
        .fe_ret_addr_i(fe_addr), .fe_ready_o(fe_ready), .pred_valid_o(pred_valid),
        .pred_target_o(pred_target), .commit_i(commit), .flush_i(flush), .rsb(rsb_if),
        .busy_o(busy), .occupancy_o(occ)
    );

    return_stack_buffer #(.ADDR_WIDTH(32), .STACK_DEPTH(8)) u_rsb (
        .clk_i(clk), .rst_i(rst), .rsb(rsb_if)
    );

    function automatic snap_t apply_op(snap_t s, logic c, logic r, logic [31:0] a);
        snap_t t = s;
        if (c && !r) begin
            if (t.n < 4'd8) begin t.e[t.n[2:0]] = a; t.n = t.n + 4'd1; end
        end else if (!c && r) begin
            if (t.n > 4'd0) t.n = t.n - 4'd1;
        end else if (c && r) begin
            if (t.n == 4'd0) begin t.e[0] = a; t.n = 4'd1; end
            else if (t.n == 4'd8) t.n = t.n - 4'd1;
            else t.e[3'(t.n - 4'd1)] = a;
        end
        return t;
    endfunction

    function automatic logic [31:0] top_of(snap_t s);
        return s.e[3'(s.n - 4'd1)];
    endfunction

    task automatic drive(input logic v, c, r, input logic [31:0] a, input logic cm, fl, rs);
        @(negedge clk);
        fe_valid = v; fe_call = c; fe_ret = r; fe_addr = a; commit = cm; flush = fl; rst = rs;
        #1;
    endtask

    // Advance one clock and move the reference model along with it.
    task automatic clock_edge();
        bit rdy;
        rdy = !rst && !unw && !flush && (snaps.size() < 8);
        @(posedge clk);
        if (rst) begin
            cur.n = 4'd0; snaps.delete(); unw = 1'b0;
        end else if (!unw) begin
            if (commit && snaps.size() > 0) void'(snaps.pop_front());
            if (fe_valid && rdy && (fe_call || fe_ret)) begin
                snaps.push_back(cur);
                cur = apply_op(cur, fe_call, fe_ret, fe_addr);
            end
            if (flush && snaps.size() > 0) unw = 1'b1;
        end else begin
            if (commit && snaps.size() > 0) void'(snaps.pop_front());
            if (snaps.size() > 0) cur = snaps.pop_back();
            if (snaps.size() == 0) unw = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 1); clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_call(input logic [31:0] a);
        drive(1, 1, 0, a, 0, 0, 0); clock_edge();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, $urandom, $urandom_range(0, 1), 0, 1);
            checks++;
            if (fe_ready !== 1'b0 || pred_valid !== 1'b0) begin
                errors++; $display("FAIL reset_comb ready=%b pred=%b want 0 0", fe_ready, pred_valid);
            end
            checks++;
            if (rsb_if.push_en !== 1'b0 || rsb_if.pop_en !== 1'b0 || rsb_if.push_addr !== 32'h0) begin
                errors++; $display("FAIL reset_cmd push=%b pop=%b addr=%h want 0 0 0",
                                   rsb_if.push_en, rsb_if.pop_en, rsb_if.push_addr);
            end
            clock_edge();
            checks++;
            if (busy !== 1'b0 || occ !== 4'd0) begin
                errors++; $display("FAIL reset_state busy=%b occ=%0d want 0 0", busy, occ);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fe_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", fe_ready); end
    endtask

    task automatic test_commit();
        do_reset();
        do_call(32'h100); do_call(32'h200);
        for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 1, 0, 0); clock_edge(); end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (rsb_if.top_addr !== 32'h200 || occ !== 4'd2 || fe_ready !== 1'b1) begin
            errors++; $display("FAIL commit_top top=%h occ=%0d ready=%b want 200 2 1", rsb_if.top_addr, occ, fe_ready);
        end
        drive(0, 0, 0, 0, 0, 1, 0); clock_edge();
        checks++;
        if (busy !== 1'b0 || occ !== 4'd2) begin
            errors++; $display("FAIL commit_noflush busy=%b occ=%0d want 0 2", busy, occ);
        end
    endtask

    task automatic test_flush_unwind();
        int n;
        do_reset();
        do_call(32'h100); do_call(32'h200);
        drive(1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h200) begin
            errors++; $display("FAIL unwind_pred valid=%b target=%h want 1 200", pred_valid, pred_target);
        end
        clock_edge();
        drive(0, 0, 0, 0, 0, 1, 0); clock_edge();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (fe_ready !== 1'b0) begin errors++; $display("FAIL unwind_ready got %b want 0", fe_ready); end
            checks++;
            if ((n == 0 && !(rsb_if.push_en === 1'b1 && rsb_if.pop_en === 1'b0 && rsb_if.push_addr === 32'h200)) ||
                (n > 0 && !(rsb_if.push_en === 1'b0 && rsb_if.pop_en === 1'b1))) begin
                errors++; $display("FAIL unwind_cmd step=%0d push=%b pop=%b addr=%h", n,
                                   rsb_if.push_en, rsb_if.pop_en, rsb_if.push_addr);
            end
            clock_edge();
            n++;
        end
        checks++;
        if (n !== 3 || occ !== 4'd0 || rsb_if.top_valid !== 1'b0) begin
            errors++; $display("FAIL unwind_len cycles=%0d occ=%0d valid=%b want 3 0 0", n, occ, rsb_if.top_valid);
        end
    endtask

    task automatic test_full();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) do_call(32'h1000 + 32'(i * 4));
        for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 0, 1, 0, 0); clock_edge(); end
        drive(1, 1, 0, 32'h900, 0, 0, 0);
        checks++;
        if (fe_ready !== 1'b1 || rsb_if.push_en !== 1'b0) begin
            errors++; $display("FAIL full_call ready=%b push=%b want 1 0", fe_ready, rsb_if.push_en);
        end
        clock_edge();
        drive(1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (pred_valid !== 1'b1 || pred_target !== 32'h101C) begin
            errors++; $display("FAIL full_pred valid=%b target=%h want 1 101c", pred_valid, pred_target);
        end
        clock_edge();
        drive(0, 0, 0, 0, 0, 1, 0); clock_edge();
        n = 0;
        while (busy === 1'b1 && n < 20) begin drive(0, 0, 0, 0, 0, 0, 0); clock_edge(); n++; end
        checks++;
        if (n !== 2 || occ !== 4'd8 || rsb_if.top_addr !== 32'h101C) begin
            errors++; $display("FAIL full_restore cycles=%0d occ=%0d top=%h want 2 8 101c", n, occ, rsb_if.top_addr);
        end
    endtask

    task automatic test_replace();
        int n;
        do_reset();
        do_call(32'h40);
        drive(0, 0, 0, 0, 1, 0, 0); clock_edge();
        drive(1, 1, 1, 32'h80, 0, 0, 0);
        checks++;
        if (rsb_if.push_en !== 1'b1 || rsb_if.pop_en !== 1'b1 || rsb_if.push_addr !== 32'h80) begin
            errors++; $display("FAIL replace_cmd push=%b pop=%b addr=%h want 1 1 80",
                               rsb_if.push_en, rsb_if.pop_en, rsb_if.push_addr);
        end
        clock_edge();
        checks++;
        if (rsb_if.top_addr !== 32'h80 || occ !== 4'd1) begin
            errors++; $display("FAIL replace_top top=%h occ=%0d want 80 1", rsb_if.top_addr, occ);
        end
        drive(0, 0, 0, 0, 0, 1, 0); clock_edge();
        n = 0;
        while (busy === 1'b1 && n < 20) begin drive(0, 0, 0, 0, 0, 0, 0); clock_edge(); n++; end
        checks++;
        if (n !== 1 || rsb_if.top_addr !== 32'h40 || occ !== 4'd1) begin
            errors++; $display("FAIL replace_restore cycles=%0d top=%h occ=%0d want 1 40 1", n, rsb_if.top_addr, occ);
        end
    endtask

    task automatic test_journal_full();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) do_call(32'h2000 + 32'(i * 4));
        drive(1, 1, 0, 32'h3000, 0, 0, 0);
        checks++;
        if (fe_ready !== 1'b0) begin errors++; $display("FAIL jfull_ready got %b want 0", fe_ready); end
        drive(0, 0, 0, 0, 1, 1, 0); clock_edge();
        n = 0;
        while (busy === 1'b1 && n < 20) begin drive(0, 0, 0, 0, 0, 0, 0); clock_edge(); n++; end
        checks++;
        if (n !== 7 || occ !== 4'd1 || rsb_if.top_addr !== 32'h2000) begin
            errors++; $display("FAIL jfull_unwind cycles=%0d occ=%0d top=%h want 7 1 2000", n, occ, rsb_if.top_addr);
        end
    endtask

    task automatic test_reset_unwind();
        do_reset();
        do_call(32'h500); do_call(32'h504); do_call(32'h508);
        drive(0, 0, 0, 0, 0, 1, 0); clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0); clock_edge();
        drive(0, 0, 0, 0, 0, 0, 1); clock_edge();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (occ !== 4'd0 || busy !== 1'b0 || fe_ready !== 1'b1) begin
            errors++; $display("FAIL rst_unwind occ=%0d busy=%b ready=%b want 0 0 1", occ, busy, fe_ready);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic v, c, r, cm, fl, rs, exp_rdy, exp_pred;
            logic [31:0] a;
            v  = ($urandom_range(0, 9) < 7);
            c  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_FFFC;
            cm = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 299) == 0);
            drive(v, c, r, a, cm, fl, rs);
            exp_rdy  = !rs && !unw && !fl && (snaps.size() < 8);
            exp_pred = !rs && !unw && v && r && (cur.n != 4'd0);
            checks++;
            if (fe_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_ready cyc=%0d got %b want %b", i, fe_ready, exp_rdy);
            end
            checks++;
            if (pred_valid !== exp_pred || (exp_pred && pred_target !== top_of(cur))) begin
                errors++; $display("FAIL rand_pred cyc=%0d got %b/%h want %b/%h", i, pred_valid, pred_target,
                                   exp_pred, top_of(cur));
            end
            clock_edge();
            checks++;
            if (occ !== cur.n || busy !== unw || rsb_if.top_valid !== (cur.n != 4'd0)) begin
                errors++; $display("FAIL rand_state cyc=%0d occ=%0d busy=%b valid=%b want %0d %b %b", i, occ, busy,
                                   rsb_if.top_valid, cur.n, unw, (cur.n != 4'd0));
            end
            if (cur.n != 4'd0) begin
                checks++;
                if (rsb_if.top_addr !== top_of(cur)) begin
                    errors++; $display("FAIL rand_top cyc=%0d got %h want %h", i, rsb_if.top_addr, top_of(cur));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; fe_valid = 1'b0; fe_call = 1'b0; fe_ret = 1'b0; fe_addr = '0;
        commit = 1'b0; flush = 1'b0;
        cur = '0; unw = 1'b0;
        test_reset();
        test_commit();
        test_flush_unwind();
        test_full();
        test_replace();
        test_journal_full();
        test_reset_unwind();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
